// File: rtl/imem_responder.sv
// imem_responder: fixed-latency instruction memory with credit-limited in-order response FIFO.
// Define IMEM_ERR_CHECK_EN to flag misaligned or out-of-range fetches.
module imem_responder #(
  parameter int ADDR_W    = 64,
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2,
  parameter int QDEPTH    = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [ADDR_W-1:0]            req_addr_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [31:0]                  rsp_data_o,
  output logic                         rsp_err_o,
  input  logic                         load_en_i,
  input  logic [$clog2(MEM_WORDS)-1:0] load_addr_i,
  input  logic [31:0]                  load_data_i,
  output logic                         busy_o
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  logic [31:0] mem [MEM_WORDS];
  logic [LATENCY-1:0] pv_q, pv_d, pe_q, pe_d;
  logic [31:0] pd_q [LATENCY];
  logic [31:0] pd_d [LATENCY];
  logic [31:0] fd_q [QDEPTH];
  logic [31:0] fd_d [QDEPTH];
  logic [QDEPTH-1:0] fe_q, fe_d;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] fc_q, fc_d, out_q, out_d;
  logic acc, pop, push, err;
  logic [AW-1:0] idx;
  assign idx = req_addr_i[AW+1:2];
`ifdef IMEM_ERR_CHECK_EN
  assign err = (|req_addr_i[1:0]) || (|(req_addr_i >> (AW + 2)));
`else
  logic unused_addr;
  assign unused_addr = ^req_addr_i;
  assign err = 1'b0;
`endif
  assign req_ready_o = out_q < CW'(QDEPTH);
  assign acc         = req_valid_i & req_ready_o;
  assign rsp_valid_o = fc_q != '0;
  assign pop         = rsp_valid_o & rsp_ready_i;
  assign push        = pv_q[LATENCY-1];
  assign rsp_data_o  = rsp_valid_o ? fd_q[rp_q] : '0;
  assign rsp_err_o   = rsp_valid_o & fe_q[rp_q];
  assign busy_o      = out_q != '0;
  always_comb begin
    pv_d[0] = acc;
    pd_d[0] = err ? 32'h0000_0013 : mem[idx];
    pe_d[0] = err;
    for (int i = 1; i < LATENCY; i++) begin
      pv_d[i] = pv_q[i-1];
      pd_d[i] = pd_q[i-1];
      pe_d[i] = pe_q[i-1];
    end
    fd_d = fd_q;
    fe_d = fe_q;
    if (push) begin
      fd_d[wp_q] = pd_q[LATENCY-1];
      fe_d[wp_q] = pe_q[LATENCY-1];
    end
    wp_d  = !push ? wp_q : (wp_q == PW'(QDEPTH - 1)) ? '0 : wp_q + 1'b1;
    rp_d  = !pop ? rp_q : (rp_q == PW'(QDEPTH - 1)) ? '0 : rp_q + 1'b1;
    fc_d  = fc_q + CW'(push) - CW'(pop);
    out_d = out_q + CW'(acc) - CW'(pop);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pv_q  <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      fc_q  <= '0;
      out_q <= '0;
    end else begin
      pv_q  <= pv_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      fc_q  <= fc_d;
      out_q <= out_d;
    end
    pd_q <= pd_d;
    pe_q <= pe_d;
    fd_q <= fd_d;
    fe_q <= fe_d;
  end
  // Storage is deliberately outside reset so contents survive it.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && load_en_i) mem[load_addr_i] <= load_data_i;
  end
endmodule
